// File: rtl/instruction_encoder.sv
// instruction_encoder
// Packs decoded RV32 fields into a 32-bit instruction word, rejects immediates
// that the chosen format cannot represent, and tags every word with a memory
// address from an auto-incrementing counter. Stage 1 packs and checks the
// bundle. Stage 2 tags the word and presents it to the sink.
module instruction_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_fmt,
    input  logic [6:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [31:0]          in_imm,
    input  logic                 addr_load,
    input  logic [31:0]          addr_val,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_inst,
    output logic [31:0]          out_addr,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [2:0]  FMT_R    = 3'd0;
    localparam logic [2:0]  FMT_I    = 3'd1;
    localparam logic [2:0]  FMT_S    = 3'd2;
    localparam logic [2:0]  FMT_B    = 3'd3;
    localparam logic [2:0]  FMT_U    = 3'd4;
    localparam logic [2:0]  FMT_J    = 3'd5;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;   // addi x0, x0, 0

    // Scatter the fields into the instruction layout of the given format.
    function automatic logic [31:0] pack_word(
        input logic [2:0]  fmt,
        input logic [6:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] imm
    );
        logic [31:0] w;
        w = NOP_INST;
        case (fmt)
            FMT_R:   w = {f7, rs2, rs1, f3, rd, op};
            FMT_I:   w = {imm[11:0], rs1, f3, rd, op};
            FMT_S:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            FMT_U:   w = {imm[31:12], rd, op};
            FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: w = NOP_INST;
        endcase
        return w;
    endfunction

    // A value fits a signed N-bit field when bits [31:N-1] are all copies of
    // the sign bit. Branch and jump offsets must also be halfword aligned.
    function automatic logic imm_reject(
        input logic [2:0]         fmt,
        input logic signed [31:0] imm
    );
        logic rej;
        case (fmt)
            FMT_R:        rej = 1'b0;
            FMT_I, FMT_S: rej = !((&imm[31:11]) || !(|imm[31:11]));
            FMT_B:        rej = imm[0] || !((&imm[31:12]) || !(|imm[31:12]));
            FMT_U:        rej = |imm[11:0];
            FMT_J:        rej = imm[0] || !((&imm[31:20]) || !(|imm[31:20]));
            default:      rej = 1'b1;
        endcase
        return rej;
    endfunction

    // Error counter sticks at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + ERR_CNT_W'(1);
    endfunction

    logic                 vld_p1_q, vld_p1_d;
    logic [31:0]          inst_p1_q, inst_p1_d;
    logic                 err_p1_q, err_p1_d;
    logic                 vld_p2_q, vld_p2_d;
    logic [31:0]          inst_p2_q, inst_p2_d;
    logic [31:0]          addr_p2_q, addr_p2_d;
    logic                 err_p2_q, err_p2_d;
    logic [31:0]          addr_cnt_q, addr_cnt_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic        adv_p1;     // stage 1 may hand its content to stage 2
    logic        accept;     // bundle transfer this cycle
    logic        load_p2;    // a real word moves from stage 1 to stage 2
    logic        rej_p0;
    logic [31:0] addr_tag;   // address given to a word entering stage 2

    assign adv_p1   = !vld_p2_q || out_ready;
    assign in_ready = !vld_p1_q || adv_p1;
    assign accept   = in_valid && in_ready;
    assign load_p2  = vld_p1_q && adv_p1;
    assign rej_p0   = imm_reject(in_fmt, in_imm);
    // A reload coincident with a stage-2 load tags that word directly.
    assign addr_tag = addr_load ? addr_val : addr_cnt_q;

    // ---- stage 0 -> 1: pack and range-check the incoming bundle
    // Stage 1 next state: capture on accept, drain when passed downstream.
    always_comb begin
        vld_p1_d  = vld_p1_q;
        inst_p1_d = inst_p1_q;
        err_p1_d  = err_p1_q;
        if (accept) begin
            vld_p1_d  = 1'b1;
            err_p1_d  = rej_p0;
            inst_p1_d = rej_p0 ? NOP_INST
                               : pack_word(in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
                                           in_funct3, in_funct7, in_imm);
        end else if (adv_p1) begin
            vld_p1_d = 1'b0;
        end
    end

    // Stage 1 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q  <= 1'b0;
            inst_p1_q <= 32'h0;
            err_p1_q  <= 1'b0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            inst_p1_q <= inst_p1_d;
            err_p1_q  <= err_p1_d;
        end
    end

    // ---- stage 1 -> 2: address tagging and error accounting
    // Stage 2, address counter and error counter next state.
    always_comb begin
        vld_p2_d   = vld_p2_q;
        inst_p2_d  = inst_p2_q;
        addr_p2_d  = addr_p2_q;
        err_p2_d   = err_p2_q;
        addr_cnt_d = addr_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (adv_p1) begin
            vld_p2_d = vld_p1_q;
        end
        if (load_p2) begin
            inst_p2_d  = inst_p1_q;
            err_p2_d   = err_p1_q;
            addr_p2_d  = addr_tag;
            addr_cnt_d = addr_tag + 32'd4;
            if (err_p1_q) begin
                err_cnt_d = sat_inc(err_cnt_q);
            end
        end else if (addr_load) begin
            addr_cnt_d = addr_val;
        end
    end

    // Stage 2 register plus the address and error counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2_q   <= 1'b0;
            inst_p2_q  <= 32'h0;
            addr_p2_q  <= 32'h0;
            err_p2_q   <= 1'b0;
            addr_cnt_q <= BASE_ADDR;
            err_cnt_q  <= '0;
        end else begin
            vld_p2_q   <= vld_p2_d;
            inst_p2_q  <= inst_p2_d;
            addr_p2_q  <= addr_p2_d;
            err_p2_q   <= err_p2_d;
            addr_cnt_q <= addr_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign out_valid = vld_p2_q;
    assign out_inst  = inst_p2_q;
    assign out_addr  = addr_p2_q;
    assign out_err   = err_p2_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder: directed scenarios with literal expectations
// plus a randomized run, all checked against an arithmetic reference model.
module tb_instruction_encoder;

    localparam logic [31:0] BASE = 32'h0000_2000;
    localparam int          ECW  = 8;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic           in_valid  = 1'b0;
    logic           in_ready;
    logic [2:0]     in_fmt    = 3'd0;
    logic [6:0]     in_opcode = 7'd0;
    logic [4:0]     in_rd     = 5'd0;
    logic [4:0]     in_rs1    = 5'd0;
    logic [4:0]     in_rs2    = 5'd0;
    logic [2:0]     in_funct3 = 3'd0;
    logic [6:0]     in_funct7 = 7'd0;
    logic [31:0]    in_imm    = 32'd0;
    logic           addr_load = 1'b0;
    logic [31:0]    addr_val  = 32'd0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [31:0]    out_inst;
    logic [31:0]    out_addr;
    logic           out_err;
    logic [ECW-1:0] err_count;

    instruction_encoder #(.BASE_ADDR(BASE), .ERR_CNT_W(ECW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_funct7(in_funct7), .in_imm(in_imm),
        .addr_load(addr_load), .addr_val(addr_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: field placement by shift/mask, legality by signed ranges.
    typedef struct packed { logic [31:0] inst; logic err; } word_t;

    function automatic word_t model_word(
        input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
        input logic [6:0] f7, input logic [31:0] imm);
        word_t r;
        longint v;
        bit ok;
        logic [31:0] o, d, a, b, g3, g7, w;
        v  = longint'($signed(imm));
        o  = 32'(op);  d  = 32'(rd);  a  = 32'(rs1);  b = 32'(rs2);
        g3 = 32'(f3);  g7 = 32'(f7);
        ok = 1'b0;
        w  = 32'h0;
        case (fmt)
            3'd0: begin
                ok = 1'b1;
                w  = (g7 << 25) | (b << 20) | (a << 15) | (g3 << 12) | (d << 7) | o;
            end
            3'd1: begin
                ok = (v >= -2048) && (v <= 2047);
                w  = ((imm & 32'hFFF) << 20) | (a << 15) | (g3 << 12) | (d << 7) | o;
            end
            3'd2: begin
                ok = (v >= -2048) && (v <= 2047);
                w  = (((imm >> 5) & 32'h7F) << 25) | (b << 20) | (a << 15) | (g3 << 12)
                   | ((imm & 32'h1F) << 7) | o;
            end
            3'd3: begin
                ok = (v >= -4096) && (v <= 4094) && (v % 2 == 0);
                w  = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                   | (b << 20) | (a << 15) | (g3 << 12)
                   | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | o;
            end
            3'd4: begin
                ok = (imm % 4096) == 0;
                w  = (imm & 32'hFFFF_F000) | (d << 7) | o;
            end
            3'd5: begin
                ok = (v >= -1048576) && (v <= 1048574) && (v % 2 == 0);
                w  = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                   | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                   | (d << 7) | o;
            end
            default: ok = 1'b0;
        endcase
        r.err  = !ok;
        r.inst = ok ? w : NOP;
        return r;
    endfunction

    word_t       q[$];
    logic [31:0] m_next_addr = BASE;
    logic [31:0] m_cur_addr  = 32'h0;
    int          m_errs      = 0;
    bit          fresh       = 1'b1;

    // Compare process: outputs checked every falling edge against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_next_addr = BASE;
            m_errs      = 0;
            fresh       = 1'b1;
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("out_valid_without_word", 32'(out_valid), 32'd0);
                end else begin
                    if (fresh) begin
                        m_cur_addr  = m_next_addr;
                        m_next_addr = m_next_addr + 32'd4;
                        if (q[0].err && m_errs < (1 << ECW) - 1) m_errs++;
                    end
                    chk("out_inst", out_inst, q[0].inst);
                    chk("out_err", 32'(out_err), 32'(q[0].err));
                    chk("out_addr", out_addr, m_cur_addr);
                end
            end
            chk("err_count", 32'(err_count), 32'(m_errs));
            if (addr_load) m_next_addr = addr_val;
            fresh = !out_valid || out_ready;
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready)
                q.push_back(model_word(in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
                                       in_funct3, in_funct7, in_imm));
        end
    end

    task automatic set_bundle(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm);
        in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    endtask

    // Offer one bundle until accepted (bounded); returns 1 ns after the accepting edge.
    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
        bit got;
        got = 1'b0;
        set_bundle(f, op, rd, rs1, rs2, f3, f7, imm);
        in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("send_accept_timeout", 32'(got), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; addr_load = 1'b0; out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    int          bnd[12] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4096, -4098,
                             -1048576, 1048574, 1048576, -1048578};
    logic [31:0] bp_exp[4] = '{32'h0010_0093, 32'h0020_0093, 32'h0030_0093, 32'h0040_0093};

    initial begin
        word_t mw;

        // model self-pins from hand-computed encodings
        mw = model_word(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        chk("model_i_neg1", mw.inst, 32'hFFF0_0093);
        mw = model_word(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
        chk("model_b_neg4", mw.inst, 32'hFE20_8EE3);
        mw = model_word(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0000_0003);
        chk("model_b_odd_err", 32'(mw.err), 32'd1);

        // reset state
        @(posedge clk); #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_addr", out_addr, 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // single I-type word and its latency
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        chk("lat_not_yet_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("i_valid", 32'(out_valid), 32'd1);
        chk("i_inst", out_inst, 32'hFFF0_0093);
        chk("i_err", 32'(out_err), 32'd0);
        chk("i_addr", out_addr, BASE);

        // B then J back to back
        do_reset();
        send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
        send(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
        chk("b_inst", out_inst, 32'hFE20_8EE3);
        chk("b_addr", out_addr, BASE);
        @(posedge clk); #1;
        chk("j_inst", out_inst, 32'h0010_006F);
        chk("j_addr", out_addr, BASE + 32'd4);

        // four rejected bundles
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
        send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0000_0003);
        send(3'd4, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0001);
        send(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0000);
        @(posedge clk); #1;
        chk("rej_inst", out_inst, NOP);
        chk("rej_err", 32'(out_err), 32'd1);
        chk("rej_err_count", 32'(err_count), 32'd4);

        // backpressure: sink stalled for six cycles while four bundles are offered
        do_reset();
        out_ready = 1'b0;
        fork
            begin : offer
                int acc;
                int cyc;
                acc = 0;
                cyc = 0;
                while (acc < 4 && cyc < 40) begin
                    set_bundle(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(acc + 1));
                    in_valid = 1'b1;
                    @(negedge clk);
                    if (cyc == 2) begin
                        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
                        chk("bp_accepts_before_stall", 32'(acc), 32'd2);
                    end
                    if (in_ready) acc++;
                    @(posedge clk); #1;
                    cyc++;
                    if (cyc == 6) out_ready = 1'b1;
                end
                in_valid = 1'b0;
                if (acc < 4) chk("bp_offer_timeout", 32'(acc), 32'd4);
            end
            begin : collect
                for (int k = 0; k < 4; k++) begin
                    bit seen;
                    seen = 1'b0;
                    for (int t = 0; t < 60; t++) begin
                        @(negedge clk);
                        if (out_valid && out_ready) begin
                            seen = 1'b1;
                            break;
                        end
                    end
                    chk("bp_word_seen", 32'(seen), 32'd1);
                    chk("bp_addr", out_addr, BASE + 32'(4 * k));
                    chk("bp_inst", out_inst, bp_exp[k]);
                end
            end
        join
        @(posedge clk); #1;

        // address reload coincident with a stage-2 load, then wrap
        do_reset();
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0010);
        addr_load = 1'b1;
        addr_val  = 32'h0000_0100;
        set_bundle(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0020);
        in_valid = 1'b1;
        @(posedge clk); #1;
        addr_load = 1'b0;
        in_valid  = 1'b0;
        chk("ld_coincident_addr", out_addr, 32'h0000_0100);
        chk("ld_coincident_inst", out_inst, 32'h0100_0093);
        @(posedge clk); #1;
        chk("ld_next_addr", out_addr, 32'h0000_0104);
        out_ready = 1'b0;
        addr_load = 1'b1;
        addr_val  = 32'hFFFF_FFFC;
        @(posedge clk); #1;
        addr_load = 1'b0;
        chk("ld_held_addr", out_addr, 32'h0000_0104);
        chk("ld_held_inst", out_inst, 32'h0200_0113);
        out_ready = 1'b1;
        send(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0030);
        send(3'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0040);
        chk("wrap_addr_top", out_addr, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        chk("wrap_addr_zero", out_addr, 32'h0000_0000);

        // reset with both stages full
        do_reset();
        out_ready = 1'b0;
        send(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0000);
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0005);
        chk("mid_err_count_before", 32'(err_count), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_err_count", 32'(err_count), 32'd0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0005);
        chk("mid_no_stale", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("mid_after_addr", out_addr, BASE);
        chk("mid_after_inst", out_inst, 32'h0050_0113);
        chk("mid_after_err_count", 32'(err_count), 32'd0);

        // error counter saturation
        set_bundle(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0000);
        in_valid = 1'b1;
        for (int i = 0; i < 260; i++) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("sat_err_count", 32'(err_count), 32'((1 << ECW) - 1));

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_fmt    = 3'($urandom_range(0, 7));
            in_opcode = 7'($urandom());
            in_rd     = 5'($urandom());
            in_rs1    = 5'($urandom());
            in_rs2    = 5'($urandom());
            in_funct3 = 3'($urandom());
            in_funct7 = 7'($urandom());
            case ($urandom_range(0, 3))
                0:       in_imm = $urandom();
                1:       in_imm = 32'(int'($urandom_range(0, 8191)) - 4096);
                2:       in_imm = 32'(bnd[$urandom_range(0, 11)]);
                default: in_imm = $urandom() & 32'hFFFF_F000;
            endcase
            out_ready = ($urandom_range(0, 9) < 7);
            addr_load = ($urandom_range(0, 31) == 0);
            addr_val  = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFF8
                                                    : ($urandom() & 32'hFFFF_FFFC);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        addr_load = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
